// File: rtl/act_stream_engine_pkg.sv
// Shared encodings for act_stream_engine: activation modes and FSM states.
package act_pkg;

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_RELU  = 2'b01;
  localparam logic [1:0] MODE_LEAKY = 2'b10;
  // 2'b11 is accepted and behaves as ReLU.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

endpackage

// File: rtl/act_stream_engine_if.sv
// SRAM-side bus of act_stream_engine: one source read port, one destination write port.
// Protocol: src_rdata is valid exactly one cycle after a cycle with src_ren=1;
// dst_wen qualifies dst_addr/dst_wdata for a single-cycle write with no back-pressure.
interface act_stream_engine_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 64
);
  logic              src_ren;
  logic [ADDR_W-1:0] src_addr;
  logic [WORD_W-1:0] src_rdata;
  logic              dst_wen;
  logic [ADDR_W-1:0] dst_addr;
  logic [WORD_W-1:0] dst_wdata;

  modport master (
    output src_ren, src_addr, dst_wen, dst_addr, dst_wdata,
    input  src_rdata
  );

  modport slave (
    input  src_ren, src_addr, dst_wen, dst_addr, dst_wdata,
    output src_rdata
  );
endinterface

// File: rtl/act_lane.sv
// Single-element combinational activation (pass / ReLU / leaky ReLU) on a
// two's-complement DATA_W value.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic        [1:0]        mode,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y
);

  // Negative inputs are passed, zeroed or arithmetically shifted; others pass through.
  always_comb begin
    y = x;
    if (x[DATA_W-1]) begin
      case (mode)
        MODE_PASS:  y = x;
        MODE_LEAKY: y = x >>> LEAKY_SHIFT;
        default:    y = '0;
      endcase
    end
  end

endmodule

// File: rtl/act_stream_engine.sv
// act_stream_engine: streams n words from a source SRAM buffer through a
// per-lane activation and writes them to a destination buffer.
// Pipeline: read issue -> rdata + activation -> registered write (2-cycle latency).
// Optional feature macro: ACT_STREAM_NEG_CNT_EN enables the negative-element counter.
module act_stream_engine
  import act_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LANES       = 4,
  parameter int ADDR_W      = 10,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 n,
  input  logic [ADDR_W-1:0]                 src_base,
  input  logic [ADDR_W-1:0]                 dst_base,
  input  logic [1:0]                        mode,
  act_stream_engine_if.master               sram,
  output logic                              busy,
  output logic                              done,
  output logic [ADDR_W+$clog2(LANES):0]     neg_cnt,
  output state_t                            dbg_state
);

  localparam int WORD_W = LANES * DATA_W;
  localparam int CNT_W  = ADDR_W + $clog2(LANES) + 1;

  state_t            state;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] iss_cnt;
  logic [1:0]        mode_q;
  logic              drain_cnt;
  logic              rd_vld;
  logic [ADDR_W-1:0] wr_ptr;
  logic [WORD_W-1:0] act_word;
  logic              accept;

  assign accept    = (state == ST_IDLE) && start;
  assign dbg_state = state;

  // Control FSM: latches the job, issues one read per cycle, then drains two cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      n_q           <= '0;
      iss_cnt       <= '0;
      mode_q        <= MODE_PASS;
      drain_cnt     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sram.src_ren  <= 1'b0;
      sram.src_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_q    <= n;
            mode_q <= mode;
            done   <= (n == '0);
            if (n != '0) begin
              state         <= ST_RUN;
              busy          <= 1'b1;
              sram.src_ren  <= 1'b1;
              sram.src_addr <= src_base;
              iss_cnt       <= ADDR_W'(1);
            end
          end
        end
        ST_RUN: begin
          // iss_cnt counts reads issued including the one presented this cycle.
          if (iss_cnt == n_q) begin
            sram.src_ren <= 1'b0;
            state        <= ST_DRAIN;
            drain_cnt    <= 1'b0;
          end else begin
            sram.src_addr <= sram.src_addr + ADDR_W'(1);
            iss_cnt       <= iss_cnt + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One activation unit per lane on the returning read word.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .DATA_W      (DATA_W),
      .LEAKY_SHIFT (LEAKY_SHIFT)
    ) u_lane (
      .mode (mode_q),
      .x    (sram.src_rdata[g*DATA_W +: DATA_W]),
      .y    (act_word[g*DATA_W +: DATA_W])
    );
  end

  // Write stage: register the activated word and its destination address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld         <= 1'b0;
      wr_ptr         <= '0;
      sram.dst_wen   <= 1'b0;
      sram.dst_addr  <= '0;
      sram.dst_wdata <= '0;
    end else begin
      rd_vld       <= sram.src_ren;
      sram.dst_wen <= rd_vld;
      if (rd_vld) begin
        sram.dst_addr  <= wr_ptr;
        sram.dst_wdata <= act_word;
      end
      if (accept) begin
        wr_ptr <= dst_base;
      end else if (rd_vld) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
    end
  end

`ifdef ACT_STREAM_NEG_CNT_EN
  localparam int LW = $clog2(LANES) + 1;

  logic [LW-1:0]    neg_word;
  logic [CNT_W:0]   neg_sum;
  logic [CNT_W-1:0] neg_q;

  // Number of negative lanes in the returning word, and the saturating sum.
  always_comb begin
    neg_word = '0;
    for (int i = 0; i < LANES; i++) begin
      neg_word = neg_word + LW'(sram.src_rdata[i*DATA_W + DATA_W - 1]);
    end
    neg_sum = {1'b0, neg_q} + (CNT_W+1)'(neg_word);
  end

  // Counter: cleared on job acceptance, updated on the edge that registers each write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= '0;
    end else if (accept) begin
      neg_q <= '0;
    end else if (rd_vld) begin
      neg_q <= neg_sum[CNT_W] ? '1 : neg_sum[CNT_W-1:0];
    end
  end

  assign neg_cnt = neg_q;
`else
  assign neg_cnt = '0;
`endif

endmodule
